bsg_downstream_rx: RTL and testbench

- Receive-side counterpart of the upstream serializer. Samples the two 8-bit off-chip data channels plus the valid strobe on the IO clock and reassembles 64-bit core words.
- Buffers assembled words in a small FIFO and presents them to the core with a valid/yumi handshake.
- Returns flow-control credit to the upstream transmitter by toggling the token line once per batch of words the core consumes.
- Sits between the pad-side IO channels and the core-side consumer inside bsg_top.

---
 rtl/bsg_downstream_rx.sv | 127 ++++++++++++
 tb/tb_bsg_downstream_rx.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/bsg_downstream_rx.sv
`default_nettype none
// ============================================================================
//  Module      : bsg_downstream_rx
//  Description : Receive side of the off-chip link. Collects channel beats
//                into core words, buffers them in a small FIFO for the core
//                (valid/yumi), and returns credit by toggling the token line
//                once per batch of consumed words.
//  Revision    : 1.0  initial release
// ============================================================================
module bsg_downstream_rx #(
   parameter int channel_width_p = 8,
   parameter int num_channels_p  = 2,
   parameter int core_width_p    = 64,
   parameter int fifo_els_p      = 8,
   parameter int token_batch_p   = 4
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              io_valid_i,
   input  logic [channel_width_p-1:0]        io_data_ch0_i,
   input  logic [channel_width_p-1:0]        io_data_ch1_i,
   output logic                              io_token_o,
   output logic                              core_valid_o,
   output logic [core_width_p-1:0]           core_data_o,
   input  logic                              core_yumi_i,
   output logic [$clog2(fifo_els_p+1)-1:0]   occupancy_o,
   output logic                              overflow_o
);

   localparam int c_BW    = num_channels_p * channel_width_p;
   localparam int c_BEATS = core_width_p / c_BW;
   localparam int c_BCW   = (c_BEATS > 1) ? $clog2(c_BEATS) : 1;
   localparam int c_PW    = (fifo_els_p > 1) ? $clog2(fifo_els_p) : 1;
   localparam int c_OW    = $clog2(fifo_els_p + 1);
   localparam int c_TCW   = (token_batch_p > 1) ? $clog2(token_batch_p) : 1;

   logic [c_BCW-1:0]        r_beat_cnt;
   logic [core_width_p-1:0] r_partial;
   logic [core_width_p-1:0] r_mem [fifo_els_p];
   logic [c_PW-1:0]         r_rd_ptr;
   logic [c_PW-1:0]         r_wr_ptr;
   logic [c_OW-1:0]         r_occ;
   logic [c_TCW-1:0]        r_tok_cnt;
   logic                    r_token;
   logic                    r_overflow;

   logic [c_BW-1:0]         w_beat;
   logic [core_width_p-1:0] w_word;
   logic                    w_complete;
   logic                    w_pop;
   logic                    w_push;

   // ch0 is the low byte of each beat
   assign w_beat     = {io_data_ch1_i, io_data_ch0_i};
   assign w_complete = io_valid_i && (r_beat_cnt == c_BCW'(c_BEATS - 1));
   // a pop only counts when there is something to pop
   assign w_pop      = core_yumi_i && (r_occ != '0);
   // a full FIFO can still accept the word if the head leaves this same edge
   assign w_push     = w_complete && ((r_occ < c_OW'(fifo_els_p)) || w_pop);

   // the completing beat supplies the top slice directly, no extra cycle
   generate
      if (c_BEATS > 1) begin : g_word_multi
         assign w_word = {w_beat, r_partial[core_width_p-c_BW-1:0]};
      end else begin : g_word_single
         assign w_word = w_beat;
      end
   endgenerate

   // beat counter and partial-word assembly
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_beat_cnt <= '0;
         r_partial  <= '0;
      end else if (io_valid_i) begin
         for (int k = 0; k < c_BEATS; k++) begin
            if (r_beat_cnt == c_BCW'(k)) r_partial[k*c_BW +: c_BW] <= w_beat;
         end
         r_beat_cnt <= w_complete ? '0 : r_beat_cnt + 1'b1;
      end
   end

   // FIFO storage; contents are don't-care while the slot is unoccupied
   always_ff @(posedge clk) begin
      if (rst && w_push) r_mem[r_wr_ptr] <= w_word;
   end

   // FIFO pointers, occupancy and sticky overflow flag
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_rd_ptr   <= '0;
         r_wr_ptr   <= '0;
         r_occ      <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_push) r_wr_ptr <= (r_wr_ptr == c_PW'(fifo_els_p - 1)) ? '0 : r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= (r_rd_ptr == c_PW'(fifo_els_p - 1)) ? '0 : r_rd_ptr + 1'b1;
         if (w_push && !w_pop)      r_occ <= r_occ + 1'b1;
         else if (w_pop && !w_push) r_occ <= r_occ - 1'b1;
         if (w_complete && !w_push) r_overflow <= 1'b1;
      end
   end

   // credit return: one toggle per token_batch_p consumed words
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_tok_cnt <= '0;
         r_token   <= 1'b0;
      end else if (w_pop) begin
         if (r_tok_cnt == c_TCW'(token_batch_p - 1)) begin
            r_tok_cnt <= '0;
            r_token   <= ~r_token;
         end else begin
            r_tok_cnt <= r_tok_cnt + 1'b1;
         end
      end
   end

   assign core_valid_o = (r_occ != '0);
   // head is forced to zero when empty so stale entries never leak out
   assign core_data_o  = core_valid_o ? r_mem[r_rd_ptr] : '0;
   assign occupancy_o  = r_occ;
   assign io_token_o   = r_token;
   assign overflow_o   = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_bsg_downstream_rx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bsg_downstream_rx
//  Description : Self-checking bench for bsg_downstream_rx with a queue-based
//                reference model, directed scenarios and random traffic.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_bsg_downstream_rx;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        io_valid_i = 1'b0;
   logic [7:0]  io_data_ch0_i = '0;
   logic [7:0]  io_data_ch1_i = '0;
   logic        io_token_o;
   logic        core_valid_o;
   logic [63:0] core_data_o;
   logic        core_yumi_i = 1'b0;
   logic [3:0]  occupancy_o;
   logic        overflow_o;

   int n_cmp = 0;
   int n_bad = 0;

   // reference model state
   logic [15:0] m_beats[$];
   logic [63:0] m_q[$];
   int          m_pops = 0;
   logic        m_tok  = 1'b0;
   logic        m_ovf  = 1'b0;

   bsg_downstream_rx dut (
      .clk          (clk),
      .rst          (rst),
      .io_valid_i   (io_valid_i),
      .io_data_ch0_i(io_data_ch0_i),
      .io_data_ch1_i(io_data_ch1_i),
      .io_token_o   (io_token_o),
      .core_valid_o (core_valid_o),
      .core_data_o  (core_data_o),
      .core_yumi_i  (core_yumi_i),
      .occupancy_o  (occupancy_o),
      .overflow_o   (overflow_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // model: beats are collected in a list; four of them make a word
   task automatic model_step(input logic v, input logic [7:0] a, input logic [7:0] b,
                             input logic y, input logic r);
      logic        pop;
      logic        full;
      logic [63:0] w;
      if (!r) begin
         m_beats.delete(); m_q.delete(); m_pops = 0; m_tok = 1'b0; m_ovf = 1'b0;
         return;
      end
      pop  = y && (m_q.size() != 0);
      full = (m_q.size() == 8);
      if (pop) begin
         void'(m_q.pop_front());
         m_pops++;
         if (m_pops == 4) begin m_pops = 0; m_tok = ~m_tok; end
      end
      if (v) begin
         m_beats.push_back({b, a});
         if (m_beats.size() == 4) begin
            w = {m_beats[3], m_beats[2], m_beats[1], m_beats[0]};
            m_beats.delete();
            if (!full || pop) m_q.push_back(w);
            else              m_ovf = 1'b1;
         end
      end
   endtask

   task automatic compare_all();
      logic [63:0] hd;
      hd = (m_q.size() != 0) ? m_q[0] : 64'h0;
      chk("core_valid", 64'(core_valid_o), 64'(m_q.size() != 0));
      chk("core_data",  core_data_o, hd);
      chk("occupancy",  64'(occupancy_o), 64'(m_q.size()));
      chk("token",      64'(io_token_o), 64'(m_tok));
      chk("overflow",   64'(overflow_o), 64'(m_ovf));
   endtask

   task automatic cycle(input logic v, input logic [7:0] a, input logic [7:0] b,
                        input logic y, input logic r);
      io_valid_i = v; io_data_ch0_i = a; io_data_ch1_i = b; core_yumi_i = y; rst = r;
      @(posedge clk);
      model_step(v, a, b, y, r);
      #1;
      compare_all();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
   endtask

   task automatic do_reset();
      cycle(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
   endtask

   task automatic send_word(input logic [63:0] w, input logic ylast);
      for (int k = 0; k < 4; k++)
         cycle(1'b1, w[16*k +: 8], w[16*k+8 +: 8], (k == 3) ? ylast : 1'b0, 1'b1);
   endtask

   logic [63:0] first_w;
   logic [63:0] new_w;

   initial begin
      // reset state
      do_reset();
      do_reset();
      chk("rst_valid", 64'(core_valid_o), 64'd0);
      chk("rst_occ",   64'(occupancy_o), 64'd0);

      // single word
      cycle(1'b1, 8'h01, 8'h02, 1'b0, 1'b1);
      cycle(1'b1, 8'h03, 8'h04, 1'b0, 1'b1);
      cycle(1'b1, 8'h05, 8'h06, 1'b0, 1'b1);
      chk("single_early_valid", 64'(core_valid_o), 64'd0);
      cycle(1'b1, 8'h07, 8'h08, 1'b0, 1'b1);
      chk("single_valid", 64'(core_valid_o), 64'd1);
      chk("single_data",  core_data_o, 64'h0807060504030201);
      chk("single_occ",   64'(occupancy_o), 64'd1);
      chk("single_token", 64'(io_token_o), 64'd0);

      // gapped beats
      do_reset();
      cycle(1'b1, 8'h01, 8'h02, 1'b0, 1'b1);
      cycle(1'b1, 8'h03, 8'h04, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) begin
         cycle(1'b0, 8'hEE, 8'hEE, 1'b0, 1'b1);
         chk("gap_no_valid", 64'(core_valid_o), 64'd0);
      end
      cycle(1'b1, 8'h05, 8'h06, 1'b0, 1'b1);
      cycle(1'b1, 8'h07, 8'h08, 1'b0, 1'b1);
      chk("gap_data", core_data_o, 64'h0807060504030201);

      // token batching
      do_reset();
      for (int i = 0; i < 8; i++) send_word({$urandom, $urandom}, 1'b0);
      for (int i = 1; i <= 8; i++) begin
         cycle(1'b0, 8'h00, 8'h00, 1'b1, 1'b1);
         chk("batch_token", 64'(io_token_o), (i >= 4 && i < 8) ? 64'd1 : 64'd0);
      end
      chk("batch_occ_end", 64'(occupancy_o), 64'd0);

      // full FIFO, ninth word dropped
      do_reset();
      first_w = 64'h1111_2222_3333_4444;
      send_word(first_w, 1'b0);
      for (int i = 1; i < 8; i++) send_word({$urandom, $urandom}, 1'b0);
      send_word(64'hDEAD_BEEF_0BAD_F00D, 1'b0);
      chk("full_ovf",  64'(overflow_o), 64'd1);
      chk("full_occ",  64'(occupancy_o), 64'd8);
      chk("full_head", core_data_o, first_w);

      // full FIFO, ninth word accepted by simultaneous pop
      do_reset();
      for (int i = 0; i < 8; i++) send_word({$urandom, $urandom}, 1'b0);
      new_w = 64'hCAFE_F00D_1234_5678;
      send_word(new_w, 1'b1);
      chk("full_pop_ovf", 64'(overflow_o), 64'd0);
      chk("full_pop_occ", 64'(occupancy_o), 64'd8);
      for (int i = 0; i < 7; i++) cycle(1'b0, 8'h00, 8'h00, 1'b1, 1'b1);
      chk("full_pop_last", core_data_o, new_w);
      cycle(1'b0, 8'h00, 8'h00, 1'b1, 1'b1);

      // reset mid-word
      do_reset();
      cycle(1'b1, 8'h11, 8'h22, 1'b0, 1'b1);
      cycle(1'b1, 8'h33, 8'h44, 1'b0, 1'b1);
      do_reset();
      chk("midrst_valid", 64'(core_valid_o), 64'd0);
      chk("midrst_data",  core_data_o, 64'd0);
      for (int i = 0; i < 4; i++) cycle(1'b1, 8'hAA, 8'hBB, 1'b0, 1'b1);
      chk("midrst_word", core_data_o, 64'hBBAABBAABBAABBAA);

      // yumi with empty FIFO
      do_reset();
      for (int i = 0; i < 5; i++) cycle(1'b0, 8'h00, 8'h00, 1'b1, 1'b1);
      chk("illegal_yumi_occ", 64'(occupancy_o), 64'd0);
      chk("illegal_yumi_tok", 64'(io_token_o), 64'd0);

      // random traffic with shifting yumi pressure
      do_reset();
      for (int i = 0; i < 4000; i++) begin
         int ypct;
         ypct = ((i / 400) % 2 == 0) ? 15 : 60;
         cycle(($urandom_range(99) < 70),
               8'($urandom), 8'($urandom),
               ($urandom_range(99) < ypct),
               !($urandom_range(999) == 0));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
